hamming_weight_seq: RTL and testbench

Sequencer that shares one byte-wide `hamming_weight_cal` datapath instance across a multi-byte input word. It accepts a word over a valid/ready handshake and feeds the word's bytes to the shared instance one per cycle, least-significant byte first. It accumulates the per-byte weights and presents the total popcount over a second valid/ready handshake. It sits between a word-producing stream source and any consumer of per-word Hamming weight.

---
 rtl/hamming_weight_seq.sv | 136 +++++++++++++
 tb/tb_hamming_weight_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hamming_weight_seq.sv
// hamming_weight_seq
//   Accepts a multi-byte word over a valid/ready handshake, weighs it one
//   byte per cycle (LSB first) through a single shared byte-wide popcount
//   unit, and returns the total Hamming weight over a second handshake.
//
//   Optional build macro: HW_SEQ_SKIP_ZERO_EN
//     When defined, CALC ends early once the remaining (already shifted)
//     bytes are all zero. The result value is the same in both builds.

// Byte-wide combinational popcount used as the shared datapath.
module hamming_weight_cal #(
    parameter int unsigned BIT_STRING_LEN     = 8,
    parameter int unsigned HAMMING_WEIGHT_LEN = 4
) (
    input  logic [BIT_STRING_LEN-1:0]     bit_string,
    output logic [HAMMING_WEIGHT_LEN-1:0] hamming_weight
);

    // Count the set bits of the input string.
    always_comb begin
        hamming_weight = '0;
        for (int unsigned i = 0; i < BIT_STRING_LEN; i++) begin
            hamming_weight = hamming_weight + HAMMING_WEIGHT_LEN'(bit_string[i]);
        end
    end

endmodule

module hamming_weight_seq #(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned WEIGHT_LEN = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*WORD_BYTES-1:0] in_word,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WEIGHT_LEN-1:0]   out_weight,
    output logic                    busy
);

    localparam int unsigned CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [8*WORD_BYTES-1:0] shreg_q;
    logic [8*WORD_BYTES-1:0] shreg_d;
    logic [WEIGHT_LEN-1:0]   acc_q;
    logic [WEIGHT_LEN-1:0]   acc_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    out_valid_q;
    logic [WEIGHT_LEN-1:0]   out_weight_q;
    logic [3:0]              byte_weight;
    logic                    last_d;

    hamming_weight_cal #(
        .BIT_STRING_LEN     (8),
        .HAMMING_WEIGHT_LEN (4)
    ) u_cal (
        .bit_string     (shreg_q[7:0]),
        .hamming_weight (byte_weight)
    );

    // Next accumulator / shift-register values and the end-of-word decision.
    always_comb begin
        acc_d   = acc_q + WEIGHT_LEN'(byte_weight);
        shreg_d = shreg_q >> 8;
        last_d  = (cnt_q == LAST_BYTE);
`ifdef HW_SEQ_SKIP_ZERO_EN
        if (shreg_d == '0) begin
            last_d = 1'b1;
        end
`endif
    end

    // Sequencer FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_weight_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shreg_q <= in_word;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q   <= acc_d;
                    shreg_q <= shreg_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_d) begin
                        out_weight_q <= acc_d;
                        out_valid_q  <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // Handshake decode depends on the state register only.
    always_comb begin
        in_ready = (state_q == IDLE);
        busy     = (state_q == CALC) || (state_q == DONE);
    end

    assign out_valid  = out_valid_q;
    assign out_weight = out_weight_q;

endmodule

// File: tb/tb_hamming_weight_seq.sv
// Directed bench for hamming_weight_seq (WORD_BYTES=4, WEIGHT_LEN=6).
module tb_hamming_weight_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_weight;
    logic        busy;

    int checks;
    int failures;

    hamming_weight_seq #(
        .WORD_BYTES (4),
        .WEIGHT_LEN (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_weight (out_weight),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called #1 after the accept edge: counts edges until out_valid rises.
    task automatic wait_result(input string tag, input int exp_w, input int exp_lat);
        int lat;
        lat = 0;
        check({tag, "_busy"}, int'(busy), 1);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_weight"}, int'(out_weight), exp_w);
    endtask

    // Presents a word at the negedge and lets it be accepted at the next edge.
    task automatic send(input string tag, input logic [31:0] w);
        @(negedge clk);
        in_word  = w;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_word(input string tag, input logic [31:0] w,
                            input int exp_w, input int exp_lat);
        out_ready = 1'b1;
        send(tag, w);
        wait_result(tag, exp_w, exp_lat);
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, int'(out_valid), 0);
        check({tag, "_busy_after"}, int'(busy), 0);
    endtask

    int lat_ff, lat_zero, lat_mixed, lat_ones, lat_one, lat_f0f0;

    initial begin
        checks   = 0;
        failures = 0;
`ifdef HW_SEQ_SKIP_ZERO_EN
        lat_ff = 1; lat_zero = 1; lat_mixed = 4; lat_ones = 4; lat_one = 1; lat_f0f0 = 2;
`else
        lat_ff = 4; lat_zero = 4; lat_mixed = 4; lat_ones = 4; lat_one = 4; lat_f0f0 = 4;
`endif
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_weight", int'(out_weight), 0);
        check("reset_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_word("ones", 32'hFFFF_FFFF, 32, lat_ones);
        run_word("mixed", 32'h8001_0F03, 8, lat_mixed);
        run_word("lowbyte", 32'h0000_00FF, 8, lat_ff);
        run_word("zero", 32'h0000_0000, 0, lat_zero);

        // Async reset while DONE holds a result: clears before any clock edge.
        out_ready = 1'b0;
        send("arst", 32'hFFFF_FFFF);
        wait_result("arst", 32, 4);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_out_weight", int'(out_weight), 0);
        check("arst_in_ready", int'(in_ready), 1);
        check("arst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-pressure in DONE with a new word waiting.
        send("bp", 32'h8001_0F03);
        wait_result("bp", 8, lat_mixed);
        in_word  = 32'h0000_F0F0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_weight", int'(out_weight), 8);
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", int'(out_valid), 0);
        check("bp_release_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_accept_in_ready", int'(in_ready), 0);
        wait_result("bp_next", 8, lat_f0f0);
        @(posedge clk);
        #1;
        check("bp_next_drop", int'(out_valid), 0);

        // Reset two cycles into CALC; the aborted word must never appear.
        send("abort", 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        check("abort_busy", int'(busy), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy_rst", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_output", int'(out_valid), 0);
        end
        run_word("after_abort", 32'h0000_0001, 1, lat_one);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
